// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer
//
// Purpose: two-digit BCD down-counter for the lab timer datapath. A preset
// (99..00) is loaded and then counted down to 00 once per TICK_DIV clocks.
// Counting can be paused and resumed. A one-cycle done pulse marks the
// arrival at 00.
//
// Parameters:
//   TICK_DIV     clk cycles per count step (1..255)
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   load         load the clamped preset into the count, abort any run
//   preset_tens  BCD tens digit of the preset (values above 9 clamp to 9)
//   preset_ones  BCD ones digit of the preset (values above 9 clamp to 9)
//   start        begin or resume counting down
//   pause        freeze the count while running
//   tens, ones   current count digits (BCD)
//   busy         high while running or paused (registered)
//   zero         count equals 00 (combinational)
//   done         one-cycle pulse when the count reaches 00 (registered)
//
// Configuration macro: AUTO_RELOAD_EN
//   When defined, the clamped preset is also kept in a preset register. On
//   reaching 00 the count reloads from it and keeps running, which makes the
//   timer periodic. A stored preset of 00 still stops in DONE.

module bcd_countdown_timer #(
    parameter int TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] preset_tens,
    input  logic [3:0] preset_ones,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       busy,
    output logic       zero,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        DONE
    } state_t;

    localparam logic [7:0] PRESC_LAST = 8'(TICK_DIV - 1);

    state_t     state, state_next;
    logic [7:0] presc, presc_next;
    logic [3:0] tens_next, ones_next;
    logic       done_next, busy_next;

`ifdef AUTO_RELOAD_EN
    logic [3:0] reload_tens, reload_ones;
    logic [3:0] reload_tens_next, reload_ones_next;
`endif

    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    assign zero = (tens == 4'd0) && (ones == 4'd0);

    // Next-state logic. Input priority is load > pause > start; rst is
    // handled in the register process. Each step borrows from tens when ones
    // is already 0.
    always_comb begin
        state_next = state;
        presc_next = presc;
        tens_next  = tens;
        ones_next  = ones;
        done_next  = 1'b0;
`ifdef AUTO_RELOAD_EN
        reload_tens_next = reload_tens;
        reload_ones_next = reload_ones;
`endif

        if (load) begin
            tens_next  = clamp_digit(preset_tens);
            ones_next  = clamp_digit(preset_ones);
            presc_next = 8'd0;
            state_next = IDLE;
`ifdef AUTO_RELOAD_EN
            reload_tens_next = clamp_digit(preset_tens);
            reload_ones_next = clamp_digit(preset_ones);
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (!zero) begin
                            state_next = RUN;
                            presc_next = 8'd0;
                        end else begin
                            done_next  = 1'b1;
                            state_next = DONE;
                        end
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_next = PAUSED;
                    end else if (presc == PRESC_LAST) begin
                        presc_next = 8'd0;
                        if (ones != 4'd0) begin
                            ones_next = ones - 4'd1;
                        end else if (tens != 4'd0) begin
                            ones_next = 4'd9;
                            tens_next = tens - 4'd1;
                        end
                        if ((tens_next == 4'd0) && (ones_next == 4'd0)) begin
                            done_next = 1'b1;
`ifdef AUTO_RELOAD_EN
                            // A stored preset of 00 cannot restart, so stop.
                            if ((reload_tens != 4'd0) || (reload_ones != 4'd0)) begin
                                tens_next = reload_tens;
                                ones_next = reload_ones;
                            end else begin
                                state_next = DONE;
                            end
`else
                            state_next = DONE;
`endif
                        end
                    end else begin
                        presc_next = presc + 8'd1;
                    end
                end
                PAUSED: begin
                    // Resume keeps the held prescaler value.
                    if (start) begin
                        state_next = RUN;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end

        busy_next = (state_next == RUN) || (state_next == PAUSED);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            presc <= 8'd0;
            tens  <= 4'd0;
            ones  <= 4'd0;
            done  <= 1'b0;
            busy  <= 1'b0;
`ifdef AUTO_RELOAD_EN
            reload_tens <= 4'd0;
            reload_ones <= 4'd0;
`endif
        end else begin
            state <= state_next;
            presc <= presc_next;
            tens  <= tens_next;
            ones  <= ones_next;
            done  <= done_next;
            busy  <= busy_next;
`ifdef AUTO_RELOAD_EN
            reload_tens <= reload_tens_next;
            reload_ones <= reload_ones_next;
`endif
        end
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb_bcd_countdown_timer
//
// Purpose: self-checking bench for bcd_countdown_timer. Two instances run side
// by side from the same stimulus, one with TICK_DIV=1 and one with
// TICK_DIV=4. A reference model tracks the count as a plain integer 0..99 and
// pushes the expected outputs for every clock edge into a queue per instance.
// A monitor pops the queues on the falling edge and compares them with the
// instance outputs. Honours AUTO_RELOAD_EN in the same way as the design.

module tb_bcd_countdown_timer;

    localparam int S_IDLE   = 0;
    localparam int S_RUN    = 1;
    localparam int S_PAUSED = 2;
    localparam int S_DONE   = 3;

    typedef struct {
        int state;
        int count;
        int presc;
        int reload;
        bit done;
        bit busy;
    } model_t;

    logic       clk;
    logic       rst;
    logic       load;
    logic [3:0] preset_tens;
    logic [3:0] preset_ones;
    logic       start;
    logic       pause;

    logic [3:0] tens1, ones1, tens4, ones4;
    logic       busy1, zero1, done1, busy4, zero4, done4;

    int checks;
    int errors;

    model_t m1, m4;
    model_t q1[$];
    model_t q4[$];

    bcd_countdown_timer #(.TICK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .load(load),
        .preset_tens(preset_tens), .preset_ones(preset_ones),
        .start(start), .pause(pause),
        .tens(tens1), .ones(ones1), .busy(busy1), .zero(zero1), .done(done1)
    );

    bcd_countdown_timer #(.TICK_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .load(load),
        .preset_tens(preset_tens), .preset_ones(preset_ones),
        .start(start), .pause(pause),
        .tens(tens4), .ones(ones4), .busy(busy4), .zero(zero4), .done(done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference behaviour for one clock edge, working on the count as a
    // decimal number rather than as digits.
    function automatic model_t model_step(input model_t s, input int div,
                                          input bit r, input bit ld,
                                          input int pt, input int po,
                                          input bit st, input bit pa);
        model_t n;
        n = s;
        n.done = 1'b0;
        if (r) begin
            n.state = S_IDLE;
            n.count = 0;
            n.presc = 0;
            n.reload = 0;
        end else if (ld) begin
            n.count  = ((pt > 9) ? 9 : pt) * 10 + ((po > 9) ? 9 : po);
            n.reload = n.count;
            n.presc  = 0;
            n.state  = S_IDLE;
        end else if (s.state == S_IDLE || s.state == S_DONE) begin
            if (st) begin
                if (s.count > 0) begin
                    n.state = S_RUN;
                    n.presc = 0;
                end else begin
                    n.done  = 1'b1;
                    n.state = S_DONE;
                end
            end
        end else if (s.state == S_RUN) begin
            if (pa) begin
                n.state = S_PAUSED;
            end else if (s.presc == div - 1) begin
                n.presc = 0;
                n.count = s.count - 1;
                if (n.count == 0) begin
                    n.done = 1'b1;
`ifdef AUTO_RELOAD_EN
                    if (s.reload > 0) n.count = s.reload;
                    else              n.state = S_DONE;
`else
                    n.state = S_DONE;
`endif
                end
            end else begin
                n.presc = s.presc + 1;
            end
        end else if (s.state == S_PAUSED) begin
            if (st) n.state = S_RUN;
        end
        n.busy = (n.state == S_RUN) || (n.state == S_PAUSED);
        return n;
    endfunction

    // Compare one expected snapshot with the outputs of one instance.
    task automatic checkOutput(input string name, input model_t e,
                               input logic [3:0] t, input logic [3:0] o,
                               input logic b, input logic z, input logic d);
        logic [3:0] et, eo;
        logic       ez;
        et = 4'(e.count / 10);
        eo = 4'(e.count % 10);
        ez = (e.count == 0);
        checks++;
        if (t !== et || o !== eo || b !== e.busy || z !== ez || d !== e.done) begin
            errors++;
            $display("[TB] FAIL %s t=%0t got tens=%0d ones=%0d busy=%b zero=%b done=%b exp tens=%0d ones=%0d busy=%b zero=%b done=%b",
                     name, $time, t, o, b, z, d, et, eo, e.busy, ez, e.done);
        end
    endtask

    // Drive one cycle of inputs, then advance past the next rising edge.
    task automatic applyStimulus(input logic r, input logic ld,
                                 input logic [3:0] pt, input logic [3:0] po,
                                 input logic st, input logic pa);
        rst         = r;
        load        = ld;
        preset_tens = pt;
        preset_ones = po;
        start       = st;
        pause       = pa;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    endtask

    // Model process: at each rising edge, advance both models on the sampled
    // inputs and queue the expected outputs.
    initial begin
        m1 = '{state: S_IDLE, count: 0, presc: 0, reload: 0, done: 1'b0, busy: 1'b0};
        m4 = m1;
        forever begin
            @(posedge clk);
            m1 = model_step(m1, 1, rst, load, int'(preset_tens), int'(preset_ones), start, pause);
            m4 = model_step(m4, 4, rst, load, int'(preset_tens), int'(preset_ones), start, pause);
            q1.push_back(m1);
            q4.push_back(m4);
        end
    end

    // Monitor: outputs are presented every cycle, so pop and compare on each
    // falling edge.
    initial begin
        model_t e;
        forever begin
            @(negedge clk);
            if (q1.size() > 0) begin
                e = q1.pop_front();
                checkOutput("div1", e, tens1, ones1, busy1, zero1, done1);
            end
            if (q4.size() > 0) begin
                e = q4.pop_front();
                checkOutput("div4", e, tens4, ones4, busy4, zero4, done4);
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; load = 1'b0; preset_tens = 4'd0; preset_ones = 4'd0;
        start = 1'b0; pause = 1'b0;

        // Reset for two cycles.
        applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        idle(2);

        // Borrow: count 12 down to 00.
        applyStimulus(1'b0, 1'b1, 4'd1, 4'd2, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
        idle(55);

        // Pause mid-run with preset 05.
        applyStimulus(1'b0, 1'b1, 4'd0, 4'd5, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
        idle(6);
        applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
        idle(25);

        // Clamp to 99, then zero-start.
        applyStimulus(1'b0, 1'b1, 4'hF, 4'hA, 1'b0, 1'b0);
        idle(2);
        applyStimulus(1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
        idle(3);

        // Load colliding with a step edge of the TICK_DIV=4 instance.
        applyStimulus(1'b0, 1'b1, 4'd0, 4'd5, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
        idle(3);
        applyStimulus(1'b0, 1'b1, 4'd0, 4'd7, 1'b0, 1'b0);
        idle(2);

        // Pause and start together while running, then resume.
        applyStimulus(1'b0, 1'b1, 4'd0, 4'd9, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
        idle(2);
        applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
        idle(3);
        applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
        idle(45);

        // Short periodic run (reloads when AUTO_RELOAD_EN is defined).
        applyStimulus(1'b0, 1'b1, 4'd0, 4'd3, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
        idle(30);

        // Reset in the middle of a run.
        applyStimulus(1'b0, 1'b1, 4'd0, 4'd4, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
        idle(3);
        applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        idle(2);

        // Randomised traffic with mostly small presets so runs complete.
        for (int i = 0; i < 1500; i++) begin
            logic r, ld, st, pa;
            logic [3:0] pt, po;
            r  = ($urandom_range(0, 199) == 0);
            ld = ($urandom_range(0, 39) == 0);
            st = ($urandom_range(0, 7) == 0);
            pa = ($urandom_range(0, 11) == 0);
            pt = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
            po = 4'($urandom_range(0, 15));
            applyStimulus(r, ld, pt, po, st, pa);
        end
        idle(2);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
